ping_pong_reader: RTL and testbench
===================================

# ping_pong_reader

Read-side controller for the two-bank ping-pong buffer between linear projection and the Qn x KnT matmul. Waits for a bank marked full by the writer, sweeps every address of that bank through port B (read latency 1), and delivers the words as a valid/ready stream with backpressure. When the bank has been fully read it releases the bank and moves to the other bank.

## Interface
- WIDTH, 16, element width in bits
- NUM_CORES_A, 2, cores along A per module
- NUM_CORES_B, 1, cores along B per module
- COL_X, 16, producer column count
- TOTAL_INPUT_W, 2, input weight groups
- Derived: MODULE_WIDTH = WIDTH*top_pkg::TOP_CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B; TOTAL_DEPTH = COL_X*TOTAL_INPUT_W; ADDR_WIDTH = $clog2(TOTAL_DEPTH)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset (already decided)
- bank_full  in  2  level per bank from the writer; held high until the matching bank_release
- bank_release  out  2  one-cycle pulse when a bank is fully read
- bank0_enb, bank1_enb  out  1  port-B enable per bank; at most one is high in any cycle
- rd_addrb  out  ADDR_WIDTH  shared port-B read address
- bank0_doutb, bank1_doutb  in  MODULE_WIDTH  port-B read data
- out_data  out  MODULE_WIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  consumer ready
- out_last  out  1  high with the final word of each bank
- active_bank_rd  out  1  bank currently owned by the reader

## Operation
- Reset values: bank_release=0, both enb=0, rd_addrb=0, out_valid=0, out_last=0, out_data=0, active_bank_rd=0. The FIFO and all counters are cleared.
- FSM states:
  - IDLE -> READ when bank_full[active_bank_rd]=1.
  - READ issues reads. It moves to RELEASE in the cycle after the read of index TOTAL_DEPTH-1 is issued.
  - RELEASE lasts exactly 1 cycle. It captures the last word, pulses bank_release[active_bank_rd], toggles active_bank_rd, and goes to IDLE.
- Issue rule: in READ, a read issues (enb of the active bank = 1) when fifo_count + inflight - pop < 2.
  - pop = out_valid & out_ready.
  - inflight = a read issued in the previous cycle.
  - The index counter advances only on issue.
- Read data is captured into a 2-entry FIFO the cycle after issue, muxed by the bank that was registered at issue time.
- Stream rules:
  - Data stays stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop.
  - out_last is tagged on the word whose index is TOTAL_DEPTH-1.
- Address order (default): rd_addrb = index, running 0..TOTAL_DEPTH-1.
- Boundary conditions:
  - bank_full of the inactive bank is ignored until that bank becomes active.
  - Both banks full: serve the active bank, then the other bank with no extra wait beyond IDLE.
  - bank_full falling mid-READ is a protocol violation; the reader continues and still releases.
  - Wrap: the index resets to 0 on entry to READ.
  - Reset mid-operation: FIFO flushed, no bank_release pulse, active_bank_rd returns to 0.

## Timing
- With out_ready held high, with bank_full[0] sampled high in cycle t (IDLE):
  - READ begins at t+1, and enb and addr 0 are high in cycle t+1.
  - doutb is valid at t+2.
  - out_valid is first high at t+3.
- Throughput with out_ready held high: 1 word/cycle. For TOTAL_DEPTH=32:
  - Issues in t+1..t+32.
  - RELEASE and the bank_release pulse at t+33.
  - IDLE at t+34; the next bank's first enb at t+35.
  - The last word (out_last) appears at t+34.
- Backpressure: with out_ready=0, issue stops once FIFO occupancy plus inflight reaches 2. No word is lost or duplicated.

## Configuration
- PP_READER_TRANSPOSE_EN defined: address order is column-major. For c in 0..COL_X-1, for w in 0..TOTAL_INPUT_W-1: rd_addrb = w*COL_X + c. Used for the KnT consumer.
- PP_READER_TRANSPOSE_EN undefined: linear order 0..TOTAL_DEPTH-1.
- Latency, throughput and out_last position are identical in both modes.

## Structure
- top_pkg gains pp_rd_state_t (IDLE, READ, RELEASE). It reuses TOP_CHUNK_SIZE; there are no new width constants.
- Sub-module pp_skid_fifo: 2-entry registered FIFO. Parameters are data width MODULE_WIDTH+1 (carrying out_last). It exposes count, push, pop and registered outputs.

## Test plan
- Reset, then bank_full=2'b01 with out_ready=1 -> addresses 0..31 on bank0_enb cycles t+1..t+32; out_data equals the bank0 contents in order; out_last on word 31; bank_release=2'b01 at t+33; active_bank_rd=1 after.
- bank_full=2'b11 held -> bank 0 fully streamed, then bank 1; exactly 64 words, 2 out_last pulses, releases 01 then 10.
- Random out_ready (50%) -> no drop or duplicate; data stable while stalled; inflight plus occupancy never exceeds 2.
- out_ready=0 for 10 cycles from t+1 -> exactly 2 reads issued and then stall; streaming resumes in order on release.
- rst_n low at word 10 -> all outputs at reset values next cycle; no bank_release; after re-assert, bank 0 re-read from address 0.
- With PP_READER_TRANSPOSE_EN -> address sequence 0,16,1,17,...,15,31.

Source files
------------

// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared constants and types for the projection / matmul datapath.
//   TOP_CHUNK_SIZE : elements per core chunk; sets the ping-pong word width.
//   pp_rd_state_t  : state encoding of the ping-pong buffer read controller.
// -----------------------------------------------------------------------------
package top_pkg;

  localparam int TOP_CHUNK_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RELEASE = 2'd2
  } pp_rd_state_t;

endpackage : top_pkg

// File: rtl/pp_skid_fifo.sv
// -----------------------------------------------------------------------------
// pp_skid_fifo
// Two-entry FIFO with registered outputs. The head entry is presented directly
// from a register, so dout_o/valid_o never depend combinationally on inputs.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write din_i (ignored when full and not popping)
//   din_i      : write data
//   pop_i      : consume the head entry (only meaningful while valid_o=1)
//   dout_o     : head entry
//   valid_o    : head entry is valid
//   count_o    : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module pp_skid_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          valid_q, valid_d;

  // Next-state of the head/tail entries and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push_i) begin
          head_d  = din_i;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (pop_i) begin
          // Head leaves; a simultaneous push lands straight in the head.
          if (push_i) begin
            head_d  = din_i;
            count_d = 2'd1;
          end else begin
            count_d = 2'd0;
          end
        end else begin
          if (push_i) begin
            tail_d  = din_i;
            count_d = 2'd2;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      2'd2: begin
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d  = din_i;
            count_d = 2'd2;
          end else begin
            count_d = 2'd1;
          end
        end else begin
          // Full and not draining: a push here would be an overflow; drop it.
          count_d = 2'd2;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
    valid_d = (count_d != 2'd0);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= {DW{1'b0}};
      tail_q  <= {DW{1'b0}};
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign dout_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule : pp_skid_fifo

// File: rtl/ping_pong_reader.sv
// -----------------------------------------------------------------------------
// ping_pong_reader
// Read-side controller of the two-bank ping-pong buffer feeding the Qn x KnT
// matmul. Waits for the active bank to be marked full, sweeps all of its
// addresses through port B (1-cycle read latency), streams the words out with
// valid/ready backpressure, then releases the bank and switches to the other.
//
// Compile-time option:
//   PP_READER_TRANSPOSE_EN : when defined, addresses are swept column-major
//                            (rd_addrb = w*COL_X + c); otherwise linearly.
//
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   bank_full[1:0]          : per-bank full level from the writer
//   bank_release[1:0]       : one-cycle pulse when a bank has been fully read
//   bank0_enb, bank1_enb    : port-B read enables (never both high)
//   rd_addrb                : shared port-B read address
//   bank0_doutb/bank1_doutb : port-B read data
//   out_data/out_valid/out_ready/out_last : output stream
//   active_bank_rd          : bank currently owned by the reader
// -----------------------------------------------------------------------------
module ping_pong_reader
  import top_pkg::*;
#(
  parameter  int WIDTH         = 16,
  parameter  int NUM_CORES_A   = 2,
  parameter  int NUM_CORES_B   = 1,
  parameter  int COL_X         = 16,
  parameter  int TOTAL_INPUT_W = 2,
  localparam int MODULE_WIDTH  = WIDTH * TOP_CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
  localparam int TOTAL_DEPTH   = COL_X * TOTAL_INPUT_W,
  localparam int ADDR_WIDTH    = $clog2(TOTAL_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              bank_full,
  output logic [1:0]              bank_release,
  output logic                    bank0_enb,
  output logic                    bank1_enb,
  output logic [ADDR_WIDTH-1:0]   rd_addrb,
  input  logic [MODULE_WIDTH-1:0] bank0_doutb,
  input  logic [MODULE_WIDTH-1:0] bank1_doutb,
  output logic [MODULE_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    active_bank_rd
);

  pp_rd_state_t          state_q, state_d;
  logic                  active_q, active_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  inflight_q, inflight_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_last_q, rd_last_d;
  logic [1:0]            bank_release_q, bank_release_d;

  logic                  pop_s;
  logic                  issue_s;
  logic                  last_idx_s;
  logic [2:0]            occ_s;
  logic [1:0]            fifo_count_s;
  logic                  fifo_valid_s;
  logic [MODULE_WIDTH:0] fifo_din_s;
  logic [MODULE_WIDTH:0] fifo_dout_s;

  // Sweep index -> port-B address.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] idx);
`ifdef PP_READER_TRANSPOSE_EN
    int c;
    int w;
    c = int'(idx) / TOTAL_INPUT_W;
    w = int'(idx) % TOTAL_INPUT_W;
    return ADDR_WIDTH'(w * COL_X + c);
`else
    return idx;
`endif
  endfunction

  assign pop_s      = fifo_valid_s & out_ready;
  assign last_idx_s = (idx_q == ADDR_WIDTH'(TOTAL_DEPTH - 1));

  // Words already committed (stored + arriving this cycle) after this cycle's
  // pop; a new read may only issue if it will still fit in the 2-entry FIFO.
  assign occ_s   = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s = (state_q == READ) && (occ_s < 3'd2);

  // Next-state and read-issue control.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    idx_d          = idx_q;
    bank_release_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (bank_full[active_q]) begin
          state_d = READ;
          idx_d   = {ADDR_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (issue_s) begin
          if (last_idx_s) begin
            state_d        = RELEASE;
            idx_d          = {ADDR_WIDTH{1'b0}};
            bank_release_d = active_q ? 2'b10 : 2'b01;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end else begin
          state_d = READ;
        end
      end
      RELEASE: begin
        // The final read's data is pushed into the FIFO during this cycle.
        state_d  = IDLE;
        active_d = ~active_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    inflight_d = issue_s;
    rd_bank_d  = issue_s ? active_q   : rd_bank_q;
    rd_last_d  = issue_s ? last_idx_s : rd_last_q;
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      active_q       <= 1'b0;
      idx_q          <= {ADDR_WIDTH{1'b0}};
      inflight_q     <= 1'b0;
      rd_bank_q      <= 1'b0;
      rd_last_q      <= 1'b0;
      bank_release_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      idx_q          <= idx_d;
      inflight_q     <= inflight_d;
      rd_bank_q      <= rd_bank_d;
      rd_last_q      <= rd_last_d;
      bank_release_q <= bank_release_d;
    end
  end

  // Read data belongs to the bank captured at issue time, not the current one,
  // since active_q may already have toggled when the last word returns.
  assign fifo_din_s = {rd_last_q, (rd_bank_q ? bank1_doutb : bank0_doutb)};

  pp_skid_fifo #(
    .DW (MODULE_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   (fifo_din_s),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .valid_o (fifo_valid_s),
    .count_o (fifo_count_s)
  );

  assign bank0_enb      = issue_s & ~active_q;
  assign bank1_enb      = issue_s &  active_q;
  assign rd_addrb       = addr_of(idx_q);
  assign out_data       = fifo_dout_s[MODULE_WIDTH-1:0];
  assign out_last       = fifo_dout_s[MODULE_WIDTH];
  assign out_valid      = fifo_valid_s;
  assign bank_release   = bank_release_q;
  assign active_bank_rd = active_q;

endmodule : ping_pong_reader

// File: tb/tb_ping_pong_reader.sv
module tb_ping_pong_reader;

  localparam int MW  = 16 * top_pkg::TOP_CHUNK_SIZE * 2 * 1;
  localparam int TD  = 32;
  localparam int AW  = 5;
  localparam int COLX = 16;
  localparam int TIW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    bank_full = 2'b00;
  logic [1:0]    bank_release;
  logic          bank0_enb, bank1_enb;
  logic [AW-1:0] rd_addrb;
  logic [MW-1:0] bank0_doutb = '0;
  logic [MW-1:0] bank1_doutb = '0;
  logic [MW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          active_bank_rd;

  int checks = 0;
  int errors = 0;
  int words_total = 0, lasts_total = 0, issues_total = 0;
  int rel0 = 0, rel1 = 0;

  logic [MW:0] exp_q[$];

  ping_pong_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bank_full      (bank_full),
    .bank_release   (bank_release),
    .bank0_enb      (bank0_enb),
    .bank1_enb      (bank1_enb),
    .rd_addrb       (rd_addrb),
    .bank0_doutb    (bank0_doutb),
    .bank1_doutb    (bank1_doutb),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .active_bank_rd (active_bank_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mkword(input int b, input int a);
    logic [MW-1:0] w;
    for (int i = 0; i < MW / 16; i++) begin
      w[i*16 +: 16] = {(b != 0) ? 4'hB : 4'hA, 4'(i), 8'(a)};
    end
    return w;
  endfunction

  function automatic int exp_addr(input int k);
`ifdef PP_READER_TRANSPOSE_EN
    return (k % TIW) * COLX + (k / TIW);
`else
    return k;
`endif
  endfunction

  task automatic chk(input bit ok, input string name, input logic [MW:0] act, input logic [MW:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bank(input int b);
    for (int k = 0; k < TD; k++) exp_q.push_back({(k == TD - 1), mkword(b, exp_addr(k))});
  endtask

  // Port-B memory model, one cycle read latency.
  always @(posedge clk) begin
    if (bank0_enb) bank0_doutb <= mkword(0, int'(rd_addrb));
    if (bank1_enb) bank1_doutb <= mkword(1, int'(rd_addrb));
  end

  // Monitor: address order, scoreboard, stall stability, occupancy, releases.
  int          iss_k = 0;
  logic        iss_bank = 1'b0;
  logic        exp_rel_bank = 1'b0;
  int          outst = 0;
  bit          prev_stall = 1'b0;
  logic [MW:0] prev_word = '0;
  always @(negedge clk) begin
    logic [MW:0] e;
    bit          issued;
    if (!rst_n) begin
      iss_k = 0; iss_bank = 1'b0; exp_rel_bank = 1'b0; outst = 0; prev_stall = 1'b0;
    end else begin
      issued = bank0_enb || bank1_enb;
      if (issued) begin
        chk(!(bank0_enb && bank1_enb), "enb_onehot", {bank1_enb, bank0_enb}, 2'b01);
        chk(bank1_enb == iss_bank, "enb_bank", bank1_enb, iss_bank);
        chk(int'(rd_addrb) == exp_addr(iss_k), "rd_addrb", rd_addrb, exp_addr(iss_k));
        issues_total++; outst++;
        iss_k++;
        if (iss_k == TD) begin iss_k = 0; iss_bank = ~iss_bank; end
      end
      if (prev_stall)
        chk(out_valid && ({out_last, out_data} == prev_word), "stall_stable", {out_last, out_data}, prev_word);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", {out_last, out_data}, '0);
        end else begin
          e = exp_q.pop_front();
          chk({out_last, out_data} == e, "word", {out_last, out_data}, e);
        end
        words_total++; outst--;
        if (out_last) lasts_total++;
      end
      if (issued) chk(outst <= 2, "outstanding", outst, 2);
      if (bank_release != 2'b00) begin
        chk(bank_release == (exp_rel_bank ? 2'b10 : 2'b01), "release", bank_release,
            exp_rel_bank ? 2'b10 : 2'b01);
        if (bank_release[0]) rel0++;
        if (bank_release[1]) rel1++;
        exp_rel_bank = ~exp_rel_bank;
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bank_full = 2'b00; out_ready = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk(bank_release == 2'b00, {tag, "_release"}, bank_release, 2'b00);
    chk(!bank0_enb && !bank1_enb, {tag, "_enb"}, {bank1_enb, bank0_enb}, 2'b00);
    chk(rd_addrb == '0, {tag, "_addr"}, rd_addrb, 0);
    chk(!out_valid, {tag, "_valid"}, out_valid, 0);
    chk(!out_last, {tag, "_last"}, out_last, 0);
    chk(out_data == '0, {tag, "_data"}, out_data, 0);
    chk(!active_bank_rd, {tag, "_active"}, active_bank_rd, 0);
  endtask

  // mode 0: ready held high, mode 1: random ready
  task automatic run_until(input int exp_rel, input int mode, input int min_cyc);
    int b0, b1, cyc;
    bit done;
    b0 = rel0; b1 = rel1; cyc = 0; done = 1'b0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rel0 > b0) bank_full[0] = 1'b0;
      if (rel1 > b1) bank_full[1] = 1'b0;
      if (cyc >= min_cyc && (rel0 - b0) + (rel1 - b1) >= exp_rel && exp_q.size() == 0 && !out_valid)
        done = 1'b1;
    end
    chk(done, "run_timeout", cyc, 3000);
  endtask

  typedef struct {
    logic [1:0] bf;
    int         mode;
    int         exp_words;
    int         exp_lasts;
    int         exp_rels;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w0, l0, r0, i0;

    vecs[0] = '{2'b01, 0, 32, 1, 1};
    vecs[1] = '{2'b11, 0, 64, 2, 2};
    vecs[2] = '{2'b01, 1, 32, 1, 1};
    vecs[3] = '{2'b11, 1, 64, 2, 2};
    vecs[4] = '{2'b10, 0, 0, 0, 0};

    // Reset state
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");

    // Cycle-accurate first bank with ready held high
    push_bank(0);
    @(posedge clk); #1;
    bank_full = 2'b01; out_ready = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin
        chk(bank0_enb == 1'b1, "t1_enb", bank0_enb, 1);
        chk(rd_addrb == '0, "t1_addr", rd_addrb, 0);
      end
      if (n == 2) chk(!out_valid, "t2_valid", out_valid, 0);
      if (n == 3) begin
        chk(out_valid == 1'b1, "t3_valid", out_valid, 1);
        chk(out_data == mkword(0, 0), "t3_data", out_data, mkword(0, 0));
      end
      if (n == 32) chk(bank0_enb && int'(rd_addrb) == exp_addr(31), "t32_issue", {bank0_enb, rd_addrb}, {1'b1, 5'(exp_addr(31))});
      if (n == 33) begin
        chk(bank_release == 2'b01, "t33_release", bank_release, 2'b01);
        chk(!bank0_enb && !bank1_enb, "t33_enb", {bank1_enb, bank0_enb}, 2'b00);
      end
      if (n == 34) begin
        chk(out_valid && out_last, "t34_last", {out_valid, out_last}, 2'b11);
        chk(active_bank_rd == 1'b1, "t34_active", active_bank_rd, 1);
      end
      if (n == 35) chk(!bank1_enb, "t35_no_bank1", bank1_enb, 0);
    end
    chk(exp_q.size() == 0, "t_drained", exp_q.size(), 0);

    // Table-driven scenarios
    for (int v = 0; v < 5; v++) begin
      do_reset();
      if (vecs[v].bf[0]) push_bank(0);
      if (vecs[v].bf[0] && vecs[v].bf[1]) push_bank(1);
      w0 = words_total; l0 = lasts_total; r0 = rel0 + rel1;
      @(posedge clk); #1;
      bank_full = vecs[v].bf; out_ready = 1'b1;
      run_until(vecs[v].exp_rels, vecs[v].mode, 40);
      chk(words_total - w0 == vecs[v].exp_words, $sformatf("v%0d_words", v), words_total - w0, vecs[v].exp_words);
      chk(lasts_total - l0 == vecs[v].exp_lasts, $sformatf("v%0d_lasts", v), lasts_total - l0, vecs[v].exp_lasts);
      chk(rel0 + rel1 - r0 == vecs[v].exp_rels, $sformatf("v%0d_rels", v), rel0 + rel1 - r0, vecs[v].exp_rels);
      chk(active_bank_rd == 1'((vecs[v].exp_rels) % 2), $sformatf("v%0d_active", v), active_bank_rd, vecs[v].exp_rels % 2);
    end

    // Backpressure from t+1: exactly two reads, then resume in order
    do_reset();
    push_bank(0);
    w0 = words_total;
    @(posedge clk); #1;
    bank_full = 2'b01; out_ready = 1'b0;
    i0 = issues_total;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(issues_total - i0 == 2, "stall_issues", issues_total - i0, 2);
    chk(out_valid == 1'b1, "stall_valid", out_valid, 1);
    run_until(1, 0, 1);
    chk(words_total - w0 == 32, "stall_words", words_total - w0, 32);

    // Reset in the middle of a bank
    do_reset();
    push_bank(0);
    w0 = words_total;
    @(posedge clk); #1;
    bank_full = 2'b01; out_ready = 1'b1;
    for (int c = 0; c < 200 && (words_total - w0) < 10; c++) begin
      @(posedge clk); #1;
    end
    chk(words_total - w0 >= 10, "mid_reach10", words_total - w0, 10);
    rst_n = 1'b0;
    exp_q.delete();
    r0 = rel0 + rel1;
    @(posedge clk); @(negedge clk);
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk(rel0 + rel1 == r0, "midrst_norelease", rel0 + rel1 - r0, 0);
    push_bank(0);
    w0 = words_total;
    run_until(1, 0, 1);
    chk(words_total - w0 == 32, "midrst_reread", words_total - w0, 32);
    chk(rel0 + rel1 - r0 == 1, "midrst_rels", rel0 + rel1 - r0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ping_pong_reader
